// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, one bit per clock,
// built from a single full-subtractor cell and a borrow flip-flop behind valid/ready handshakes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a_msb, b_msb;
  logic             d, br_next, last, accept;

  // Full-subtractor cell on the current LSBs and the running borrow.
  assign d       = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign last    = (cnt == CW'(WIDTH - 1));
  assign accept  = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (accept)    state_next = SHIFT;
      SHIFT:   if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // NOTE: only the visible results are reset; shift registers, borrow and counter are
  // always reloaded on accept, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
          end
        end
        SHIFT: begin
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          diff <= {d, diff[WIDTH-1:1]};
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          if (last) begin
            bout <= br_next;
            // Operands of differing sign overflow when the result sign departs from a's.
            ovf  <= (a_msb != b_msb) & (d != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 and WIDTH=2 instances against an
// arithmetic transaction model, plus directed vectors with hand-computed results.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       in_valid8 = 1'b0, out_ready8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, bout8, ovf8;
  logic [7:0] diff8;

  // WIDTH=2 instance
  logic       in_valid2 = 1'b0, out_ready2 = 1'b0, bin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       in_ready2, out_valid2, bout2, ovf2;
  logic [1:0] diff2;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8), .diff(diff8),
    .bout(bout8), .ovf(ovf8));

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .bin(bin2), .out_valid(out_valid2), .out_ready(out_ready2), .diff(diff2),
    .bout(bout2), .ovf(ovf2));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction model: busy from accept until the result handshake; result valid
  // exactly WIDTH edges after accept; values from plain integer arithmetic.
  logic       m_armed = 1'b0;
  logic       m8_busy = 1'b0, m8_clear = 1'b0, m8_bout = 1'b0, m8_ovf = 1'b0;
  int         m8_age = 0, m8_ops = 0, m8_full = 0, m8_sres = 0;
  logic [7:0] m8_diff = '0;
  logic       m2_busy = 1'b0, m2_clear = 1'b0, m2_bout = 1'b0, m2_ovf = 1'b0;
  int         m2_age = 0, m2_ops = 0, m2_full = 0, m2_sres = 0;
  logic [1:0] m2_diff = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_armed  = 1'b1;
      m8_busy  = 1'b0; m8_clear = 1'b1;
      m2_busy  = 1'b0; m2_clear = 1'b1;
    end else begin
      if (!m8_busy) begin
        if (in_valid8) begin
          m8_busy  = 1'b1; m8_age = 0; m8_clear = 1'b0; m8_ops++;
          m8_full  = int'(a8) - int'(b8) - int'(bin8);
          m8_sres  = int'($signed(a8)) - int'($signed(b8)) - int'(bin8);
          m8_diff  = 8'(m8_full);
          m8_bout  = (m8_full < 0);
          m8_ovf   = (m8_sres < -128) || (m8_sres > 127);
        end
      end else if (m8_age < 8) m8_age++;
      else if (out_ready8) m8_busy = 1'b0;

      if (!m2_busy) begin
        if (in_valid2) begin
          m2_busy  = 1'b1; m2_age = 0; m2_clear = 1'b0; m2_ops++;
          m2_full  = int'(a2) - int'(b2) - int'(bin2);
          m2_sres  = int'($signed(a2)) - int'($signed(b2)) - int'(bin2);
          m2_diff  = 2'(m2_full);
          m2_bout  = (m2_full < 0);
          m2_ovf   = (m2_sres < -2) || (m2_sres > 1);
        end
      end else if (m2_age < 2) m2_age++;
      else if (out_ready2) m2_busy = 1'b0;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (m_armed) begin
      check("in_ready8", 32'(in_ready8), 32'(!m8_busy));
      check("out_valid8", 32'(out_valid8), 32'(m8_busy && m8_age == 8));
      if (m8_busy && m8_age == 8) begin
        check("diff8", 32'(diff8), 32'(m8_diff));
        check("bout8", 32'(bout8), 32'(m8_bout));
        check("ovf8",  32'(ovf8),  32'(m8_ovf));
      end else if (m8_clear) begin
        check("rst_outs8", 32'({bout8, ovf8, diff8}), 32'(0));
      end
      check("in_ready2", 32'(in_ready2), 32'(!m2_busy));
      check("out_valid2", 32'(out_valid2), 32'(m2_busy && m2_age == 2));
      if (m2_busy && m2_age == 2) begin
        check("diff2", 32'(diff2), 32'(m2_diff));
        check("bout2", 32'(bout2), 32'(m2_bout));
        check("ovf2",  32'(ovf2),  32'(m2_ovf));
      end else if (m2_clear) begin
        check("rst_outs2", 32'({bout2, ovf2, diff2}), 32'(0));
      end
    end
  end

  // One directed WIDTH=8 operation; while busy, in_valid stays high with other operands.
  task automatic run_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tbin, input logic [7:0] ed, input logic eb,
                        input logic eo, input int stall);
    int n;
    n = 0;
    while (!in_ready8 && n < 50) begin @(posedge clk); #1; n++; end
    a8 = ta; b8 = tb; bin8 = tbin; in_valid8 = 1'b1; out_ready8 = (stall == 0);
    @(posedge clk); #1;
    a8 = ~ta; b8 = ta ^ 8'h55; bin8 = ~tbin;
    n = 0;
    while (!out_valid8 && n < 50) begin @(posedge clk); #1; n++; end
    check({name, "_latency"}, 32'(n), 32'(8));
    check({name, "_diff"}, 32'(diff8), 32'(ed));
    check({name, "_bout"}, 32'(bout8), 32'(eb));
    check({name, "_ovf"},  32'(ovf8),  32'(eo));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({name, "_hold_valid"}, 32'(out_valid8), 32'(1));
      check({name, "_hold_diff"}, 32'(diff8), 32'(ed));
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk); #1;
    check({name, "_ready_back"}, 32'(in_ready8), 32'(1));
    check({name, "_valid_drop"}, 32'(out_valid8), 32'(0));
  endtask

  initial begin
    int target8, target2;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", 32'(in_ready8), 32'(1));
    check("reset_out_valid", 32'(out_valid8), 32'(0));
    check("reset_diff", 32'(diff8), 32'(0));

    run_op("t1_5a_3c",  8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 0);
    run_op("t2_00_01",  8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
    run_op("t2_80_01",  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
    run_op("t3_10_10b", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    run_op("t3_7f_ff",  8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0);
    run_op("t4_stall",  8'hC3, 8'h5A, 1'b1, 8'h68, 1'b0, 1'b1, 5);

    // Abort an operation with reset at cnt==3.
    a8 = 8'hAA; b8 = 8'h11; bin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_in_ready", 32'(in_ready8), 32'(1));
    check("abort_out_valid", 32'(out_valid8), 32'(0));
    check("abort_outs", 32'({bout8, ovf8, diff8}), 32'(0));
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", 32'(out_valid8), 32'(0));
    end
    run_op("t5_03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 0);

    // Randomised sweeps with input bursts and output stalls on both widths.
    target8 = m8_ops + 1000;
    target2 = m2_ops + 1000;
    fork
      begin
        int cyc;
        cyc = 0;
        while (m8_ops < target8 && cyc < 40000) begin
          in_valid8  = 1'($urandom_range(0, 1));
          a8         = 8'($urandom);
          b8         = 8'($urandom);
          bin8       = 1'($urandom_range(0, 1));
          out_ready8 = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1; cyc++;
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        check("sweep8_ops_done", 32'(m8_ops >= target8), 32'(1));
      end
      begin
        int cyc;
        cyc = 0;
        while (m2_ops < target2 && cyc < 40000) begin
          in_valid2  = 1'($urandom_range(0, 1));
          a2         = 2'($urandom);
          b2         = 2'($urandom);
          bin2       = 1'($urandom_range(0, 1));
          out_ready2 = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1; cyc++;
        end
        in_valid2 = 1'b0; out_ready2 = 1'b1;
        check("sweep2_ops_done", 32'(m2_ops >= target2), 32'(1));
      end
    join
    repeat (20) @(posedge clk);
    #1;
    check("drain_idle8", 32'(in_ready8), 32'(1));
    check("drain_idle2", 32'(in_ready2), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
